stopwatch_lap_timer: RTL and testbench
======================================

Name: stopwatch_lap_timer

Overview:
Parametrised successor to the MM:SS stopwatch. Adds a count-down timer mode with a terminal "done" state, a configurable minute wrap limit, and a lap-capture FIFO that a display or UART block can read. It sits between the clock-divider pulse generators (tick_1hz, tick_2hz) and the seven-segment or readout logic. All logic runs on clk_100mhz; the ticks are single-cycle enables, not clocks.

Parameters:
MIN_MAX, 59, highest minute value in BCD range. Legal range 1..99. Minutes wrap to 00 after this value.
LAP_DEPTH, 4, number of entries in the lap FIFO. Must be a power of 2, from 2 to 16.
LAP_CW, 3, width of lap_count. Equals log2(LAP_DEPTH)+1.

Ports:
clk_100mhz  in  1  system clock.
rst  in  1  synchronous, active-high reset.
tick_1hz  in  1  one-cycle count enable.
tick_2hz  in  1  one-cycle adjust enable.
btn_run  in  1  run/pause button. Level input; the block detects rising edges internally.
btn_lap  in  1  lap/clear button. Level input; rising edge detected.
sw_adj  in  1  adjust-mode switch.
sw_sel  in  1  adjust field select: 1 = seconds, 0 = minutes.
sw_down  in  1  count direction: 1 = count down.
lap_rd  in  1  pop the head of the lap FIFO.
bcd_min_tens, bcd_min_ones, bcd_sec_tens, bcd_sec_ones  out  4 each  live time.
lap_data  out  16  FIFO head, packed {min_tens, min_ones, sec_tens, sec_ones}. Show-ahead.
lap_valid  out  1  FIFO not empty.
lap_count  out  LAP_CW  current FIFO occupancy.
lap_ovf  out  1  sticky flag: a lap was dropped because the FIFO was full.
done  out  1  count-down reached 00:00.
state_out  out  2  FSM state encoding.
is_adj  out  1  state is ADJ.
is_sel_sec  out  1  registered copy of sw_sel.

Behaviour:
- Reset: time is 00:00 and the FIFO is empty.
  - lap_data = 0, lap_valid = 0, lap_count = 0, lap_ovf = 0, done = 0.
  - state_out = 00 (IDLE), is_adj = 0, is_sel_sec = 0.
  - The button-edge history registers are cleared to 0, so a button already held high at reset release produces an edge.
  - A reset asserted mid-operation overrides everything in that same cycle.
- Edge detect: run_e = btn_run & ~btn_run_q, and likewise lap_e for btn_lap.
- Latency: every output is registered. An input event sampled at edge N is visible after edge N.
- FSM encoding: IDLE 00, RUN 01, ADJ 10, DONE 11.
- Priority order (highest first):
  1. rst.
  2. sw_adj=1 forces ADJ from IDLE or RUN. From DONE, sw_adj=1 enters ADJ and clears done.
  3. All other transitions.
- IDLE:
  - run_e goes to RUN.
  - lap_e clears the time to 00:00, flushes the FIFO (lap_count = 0) and clears lap_ovf.
  - Ticks are ignored.
- RUN:
  - run_e goes to IDLE.
  - On tick_1hz with sw_down=0, count up:
    - sec 59 rolls to 00 and min increments.
    - MIN_MAX:59 wraps to 00:00 and the block stays in RUN.
  - On tick_1hz with sw_down=1, count down:
    - sec 00 becomes 59 and min decrements.
    - A decrement that lands on 00:00 moves to DONE with done=1 in that same update.
    - A tick while already at 00:00 moves to DONE with no time change.
  - sw_down changes take effect at the next tick.
- ADJ:
  - On each tick_2hz while btn_run is high (level, not edge), increment the selected field.
    - Seconds go 59 to 00 with no carry into minutes.
    - Minutes go MIN_MAX to 00.
  - Run edges, tick_1hz and lap edges are ignored.
  - sw_adj=0 goes to IDLE.
- DONE:
  - Time holds and done=1.
  - run_e goes to IDLE and clears done.
  - lap_e is ignored.
- Lap FIFO:
  - Push: lap_e in RUN pushes the current time as it stands before any same-cycle tick update.
  - Full: a push when full is dropped and sets lap_ovf.
  - Pop: lap_rd while lap_valid advances the head. lap_rd while empty is ignored.
  - Full with simultaneous push and pop: both take effect and the count is unchanged.
  - Empty with simultaneous push and pop: the push takes effect and the pop is ignored.
  - The IDLE flush has priority over a same-cycle lap_rd.
- Simultaneous run_e and tick_1hz in RUN: the tick is applied and the state still moves to IDLE.

Test Plan:
- Reset, then run_e, then 5 tick_1hz pulses, then run_e: expect 00:05 in IDLE (state 00). A further 10 ticks leave the time unchanged.
- sw_adj=1, sw_sel=1 with btn_run held high for 6 tick_2hz pulses: 00:05 becomes 00:11. Then sw_sel=0 and 4 more pulses: 04:11. Then sw_adj=0: state 00, time 04:11.
- From 04:11, run 50 ticks counting up: expect 05:01. With MIN_MAX=2 starting from 02:59, one tick gives 00:00 and the state stays RUN.
- Count down: adjust to 00:03, set sw_down=1, then run_e plus 3 ticks. Expect 00:00, state 11 and done=1 in the cycle after the third tick. run_e then gives state 00 and done=0.
- Laps with LAP_DEPTH=4: issue 5 lap_e pulses in RUN at distinct times. Expect lap_count=4, lap_ovf=1, and lap_data equal to the first capture. 4 lap_rd pulses return the captures in order, then lap_valid=0. lap_e in IDLE then clears lap_ovf and the time.
- Boundary: lap_rd together with lap_e when the FIFO is full leaves lap_count=4 with no overflow. rst asserted mid-RUN returns all outputs to their reset values after one edge.

Source files
------------

// File: rtl/stopwatch_lap_timer.sv
// stopwatch_lap_timer: BCD MM:SS stopwatch with count-down, adjust mode and a lap-capture FIFO.
module stopwatch_lap_timer #(
  parameter int MIN_MAX   = 59,
  parameter int LAP_DEPTH = 4,
  parameter int LAP_CW    = 3
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic              tick_2hz,
  input  logic              btn_run,
  input  logic              btn_lap,
  input  logic              sw_adj,
  input  logic              sw_sel,
  input  logic              sw_down,
  input  logic              lap_rd,
  output logic [3:0]        bcd_min_tens,
  output logic [3:0]        bcd_min_ones,
  output logic [3:0]        bcd_sec_tens,
  output logic [3:0]        bcd_sec_ones,
  output logic [15:0]       lap_data,
  output logic              lap_valid,
  output logic [LAP_CW-1:0] lap_count,
  output logic              lap_ovf,
  output logic              done,
  output logic [1:0]        state_out,
  output logic              is_adj,
  output logic              is_sel_sec
);
  localparam int AW = $clog2(LAP_DEPTH);
  localparam logic [7:0] MMAX = 8'((MIN_MAX / 10) * 16 + MIN_MAX % 10);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, ADJ = 2'b10, DONE = 2'b11} state_t;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mx);
    return v == mx ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'h0} : v + 8'd1;
  endfunction
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mx);
    return v == 8'h00 ? mx : v[3:0] == 4'd0 ? {v[7:4] - 4'd1, 4'h9} : v - 8'd1;
  endfunction
  state_t            state_q;
  logic [7:0]        min_q, sec_q;
  logic              done_q, run_q, lap_q, sel_q, ovf_q;
  logic [AW-1:0]     wp_q, rp_q;
  logic [LAP_CW-1:0] cnt_q;
  logic [15:0]       mem_q [LAP_DEPTH];
  logic              run_e, lap_e, push, pop, full, wr, flush, at_zero, dn_zero;
  logic [7:0]        up_min, up_sec, dn_min, dn_sec;
  assign run_e   = btn_run & ~run_q;
  assign lap_e   = btn_lap & ~lap_q;
  assign up_sec  = bcd_inc(sec_q, 8'h59);
  assign up_min  = sec_q == 8'h59 ? bcd_inc(min_q, MMAX) : min_q;
  assign dn_sec  = bcd_dec(sec_q, 8'h59);
  assign dn_min  = sec_q == 8'h00 ? bcd_dec(min_q, MMAX) : min_q;
  assign at_zero = {min_q, sec_q} == 16'h0;
  assign dn_zero = {dn_min, dn_sec} == 16'h0;
  assign push    = lap_e & (state_q == RUN) & ~sw_adj;
  assign pop     = lap_rd & (cnt_q != '0);
  assign full    = cnt_q == LAP_CW'(LAP_DEPTH);
  assign wr      = push & (~full | pop);
  assign flush   = (state_q == IDLE) & ~sw_adj & ~run_e & lap_e;
  always_ff @(posedge clk_100mhz)
    if (wr && !flush) mem_q[wp_q] <= {min_q, sec_q};
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q <= IDLE;
      min_q   <= '0;
      sec_q   <= '0;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
      lap_q   <= 1'b0;
      sel_q   <= 1'b0;
      ovf_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      run_q <= btn_run;
      lap_q <= btn_lap;
      sel_q <= sw_sel;
      if (flush) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (wr) wp_q <= wp_q + AW'(1);
        if (pop) rp_q <= rp_q + AW'(1);
        if (push && full && !pop) ovf_q <= 1'b1;
        cnt_q <= cnt_q + LAP_CW'(wr) - LAP_CW'(pop);
      end
      case (state_q)
        IDLE:
          if (sw_adj) state_q <= ADJ;
          else if (run_e) state_q <= RUN;
          else if (lap_e) begin
            min_q <= '0;
            sec_q <= '0;
          end
        RUN:
          if (sw_adj) state_q <= ADJ;
          else begin
            if (tick_1hz && !sw_down) begin
              min_q <= up_min;
              sec_q <= up_sec;
            end
            if (tick_1hz && sw_down && !at_zero) begin
              min_q <= dn_min;
              sec_q <= dn_sec;
            end
            // a run edge wins the state even when the same tick would finish the count-down
            if (run_e) state_q <= IDLE;
            else if (tick_1hz && sw_down && (at_zero || dn_zero)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        ADJ:
          if (!sw_adj) state_q <= IDLE;
          else if (tick_2hz && btn_run) begin
            if (sw_sel) sec_q <= bcd_inc(sec_q, 8'h59);
            else min_q <= bcd_inc(min_q, MMAX);
          end
        DONE:
          if (sw_adj || run_e) begin
            state_q <= sw_adj ? ADJ : IDLE;
            done_q  <= 1'b0;
          end
      endcase
    end
  end
  assign {bcd_min_tens, bcd_min_ones} = min_q;
  assign {bcd_sec_tens, bcd_sec_ones} = sec_q;
  assign lap_valid  = cnt_q != '0;
  assign lap_data   = lap_valid ? mem_q[rp_q] : 16'h0;
  assign lap_count  = cnt_q;
  assign lap_ovf    = ovf_q;
  assign done       = done_q;
  assign state_out  = state_q;
  assign is_adj     = state_q == ADJ;
  assign is_sel_sec = sel_q;
endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// tb_stopwatch_lap_timer: directed checks of counting, adjust, count-down, lap FIFO and reset.
module tb_stopwatch_lap_timer;
  logic clk = 1'b0, rst = 1'b1;
  logic tick_1hz = 0, tick_2hz = 0, btn_run = 0, btn_lap = 0;
  logic sw_adj = 0, sw_sel = 0, sw_down = 0, lap_rd = 0;
  logic [3:0] mt, mo, st, so, w_mt, w_mo, w_st, w_so;
  logic [15:0] lap_data, w_lap_data;
  logic lap_valid, lap_ovf, done, is_adj, is_sel_sec;
  logic w_lap_valid, w_lap_ovf, w_done, w_is_adj, w_is_sel_sec;
  logic [2:0] lap_count, w_lap_count;
  logic [1:0] state_out, w_state_out;
  logic [15:0] tm, w_tm;
  int checks = 0, passed = 0;
  assign tm = {mt, mo, st, so};
  assign w_tm = {w_mt, w_mo, w_st, w_so};
  always #5 clk = ~clk;
  stopwatch_lap_timer dut (
    .clk_100mhz(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .btn_run(btn_run), .btn_lap(btn_lap), .sw_adj(sw_adj), .sw_sel(sw_sel),
    .sw_down(sw_down), .lap_rd(lap_rd), .bcd_min_tens(mt), .bcd_min_ones(mo),
    .bcd_sec_tens(st), .bcd_sec_ones(so), .lap_data(lap_data), .lap_valid(lap_valid),
    .lap_count(lap_count), .lap_ovf(lap_ovf), .done(done), .state_out(state_out),
    .is_adj(is_adj), .is_sel_sec(is_sel_sec));
  stopwatch_lap_timer #(.MIN_MAX(2)) dut2 (
    .clk_100mhz(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .btn_run(btn_run), .btn_lap(btn_lap), .sw_adj(sw_adj), .sw_sel(sw_sel),
    .sw_down(sw_down), .lap_rd(lap_rd), .bcd_min_tens(w_mt), .bcd_min_ones(w_mo),
    .bcd_sec_tens(w_st), .bcd_sec_ones(w_so), .lap_data(w_lap_data), .lap_valid(w_lap_valid),
    .lap_count(w_lap_count), .lap_ovf(w_lap_ovf), .done(w_done), .state_out(w_state_out),
    .is_adj(w_is_adj), .is_sel_sec(w_is_sel_sec));
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_run();
    btn_run = 1; cyc(); btn_run = 0; cyc();
  endtask
  task automatic pulse_lap();
    btn_lap = 1; cyc(); btn_lap = 0; cyc();
  endtask
  task automatic tick1(input int n);
    repeat (n) begin tick_1hz = 1; cyc(); tick_1hz = 0; cyc(); end
  endtask
  task automatic tick2(input int n);
    repeat (n) begin tick_2hz = 1; cyc(); tick_2hz = 0; cyc(); end
  endtask
  task automatic test_reset();
    rst = 1; cyc(2); rst = 0;
    checks++; if (tm !== 16'h0000) $display("FAIL reset_time got %h exp 0000", tm); else passed++;
    checks++; if ({state_out, is_adj, is_sel_sec, done} !== 5'b0) $display("FAIL reset_ctrl got %b exp 00000", {state_out, is_adj, is_sel_sec, done}); else passed++;
    checks++; if ({lap_data, lap_valid, lap_count, lap_ovf} !== 21'h0) $display("FAIL reset_fifo got %h exp 0", {lap_data, lap_valid, lap_count, lap_ovf}); else passed++;
  endtask
  task automatic test_count_up();
    pulse_run();
    checks++; if (state_out !== 2'b01) $display("FAIL run_state got %b exp 01", state_out); else passed++;
    tick1(5); pulse_run();
    checks++; if ({state_out, tm} !== {2'b00, 16'h0005}) $display("FAIL up5 got %b %h exp 00 0005", state_out, tm); else passed++;
    tick1(10);
    checks++; if (tm !== 16'h0005) $display("FAIL idle_ticks got %h exp 0005", tm); else passed++;
  endtask
  task automatic test_adjust();
    sw_adj = 1; sw_sel = 1; cyc();
    checks++; if ({state_out, is_adj, is_sel_sec} !== 4'b1011) $display("FAIL adj_enter got %b exp 1011", {state_out, is_adj, is_sel_sec}); else passed++;
    btn_run = 1; tick2(6);
    checks++; if (tm !== 16'h0011) $display("FAIL adj_sec got %h exp 0011", tm); else passed++;
    sw_sel = 0; tick2(4);
    checks++; if (tm !== 16'h0411) $display("FAIL adj_min got %h exp 0411", tm); else passed++;
    btn_run = 0; sw_adj = 0; cyc();
    checks++; if ({state_out, tm} !== {2'b00, 16'h0411}) $display("FAIL adj_exit got %b %h exp 00 0411", state_out, tm); else passed++;
  endtask
  task automatic test_run_50();
    pulse_run(); tick1(50);
    checks++; if ({state_out, tm} !== {2'b01, 16'h0501}) $display("FAIL up50 got %b %h exp 01 0501", state_out, tm); else passed++;
    pulse_run();
  endtask
  task automatic test_count_down();
    pulse_lap();
    checks++; if (tm !== 16'h0000) $display("FAIL idle_clear got %h exp 0000", tm); else passed++;
    sw_adj = 1; sw_sel = 1; cyc(); btn_run = 1; tick2(3); btn_run = 0; sw_adj = 0; cyc();
    sw_down = 1; pulse_run(); tick1(2);
    checks++; if ({state_out, done, tm} !== {2'b01, 1'b0, 16'h0001}) $display("FAIL down2 got %b %b %h exp 01 0 0001", state_out, done, tm); else passed++;
    tick_1hz = 1; cyc();
    checks++; if ({state_out, done, tm} !== {2'b11, 1'b1, 16'h0000}) $display("FAIL down_done got %b %b %h exp 11 1 0000", state_out, done, tm); else passed++;
    tick_1hz = 0; cyc(); tick1(1);
    checks++; if ({state_out, tm} !== {2'b11, 16'h0000}) $display("FAIL done_hold got %b %h exp 11 0000", state_out, tm); else passed++;
    pulse_run();
    checks++; if ({state_out, done} !== 3'b000) $display("FAIL done_exit got %b exp 000", {state_out, done}); else passed++;
    pulse_run(); tick1(1);
    checks++; if ({state_out, done, tm} !== {2'b11, 1'b1, 16'h0000}) $display("FAIL zero_tick got %b %b %h exp 11 1 0000", state_out, done, tm); else passed++;
    pulse_run(); sw_down = 0;
  endtask
  task automatic test_laps();
    pulse_run();
    for (int i = 0; i < 5; i++) begin tick1(1); pulse_lap(); end
    checks++; if ({lap_count, lap_ovf, lap_valid, lap_data} !== {3'd4, 1'b1, 1'b1, 16'h0001}) $display("FAIL lap_full got %0d %b %b %h exp 4 1 1 0001", lap_count, lap_ovf, lap_valid, lap_data); else passed++;
    pulse_run();
    for (int i = 1; i <= 4; i++) begin
      checks++; if (lap_data !== 16'(i)) $display("FAIL lap_pop%0d got %h exp %h", i, lap_data, 16'(i)); else passed++;
      lap_rd = 1; cyc(); lap_rd = 0;
    end
    checks++; if ({lap_valid, lap_count} !== 4'b0) $display("FAIL lap_empty got %b %0d exp 0 0", lap_valid, lap_count); else passed++;
    pulse_lap();
    checks++; if ({lap_ovf, tm} !== {1'b0, 16'h0000}) $display("FAIL lap_clear got %b %h exp 0 0000", lap_ovf, tm); else passed++;
  endtask
  task automatic test_back_to_back();
    pulse_run();
    for (int i = 0; i < 4; i++) begin tick1(1); pulse_lap(); end
    tick1(1);
    btn_lap = 1; lap_rd = 1; cyc(); btn_lap = 0; lap_rd = 0; cyc();
    checks++; if ({lap_count, lap_ovf, lap_data} !== {3'd4, 1'b0, 16'h0002}) $display("FAIL full_pushpop got %0d %b %h exp 4 0 0002", lap_count, lap_ovf, lap_data); else passed++;
    pulse_run();
    btn_lap = 1; lap_rd = 1; cyc(); btn_lap = 0; lap_rd = 0; cyc();
    checks++; if ({lap_count, lap_valid} !== 4'b0) $display("FAIL flush_prio got %0d %b exp 0 0", lap_count, lap_valid); else passed++;
    pulse_run();
    btn_lap = 1; lap_rd = 1; cyc(); btn_lap = 0; lap_rd = 0; cyc();
    checks++; if ({lap_count, lap_valid} !== {3'd1, 1'b1}) $display("FAIL empty_pushpop got %0d %b exp 1 1", lap_count, lap_valid); else passed++;
  endtask
  task automatic test_mid_run_reset();
    tick1(3);
    checks++; if ({state_out, tm} !== {2'b01, 16'h0003}) $display("FAIL pre_reset got %b %h exp 01 0003", state_out, tm); else passed++;
    rst = 1; cyc(); rst = 0;
    checks++; if ({state_out, done, tm, lap_count, lap_valid, lap_ovf, lap_data} !== '0) $display("FAIL mid_reset got %b %b %h %0d %b %b %h exp all zero", state_out, done, tm, lap_count, lap_valid, lap_ovf, lap_data); else passed++;
  endtask
  task automatic test_wrap();
    sw_adj = 1; sw_sel = 0; cyc(); btn_run = 1; tick2(2);
    sw_sel = 1; tick2(59); btn_run = 0; sw_adj = 0; cyc();
    checks++; if (w_tm !== 16'h0259) $display("FAIL wrap_setup got %h exp 0259", w_tm); else passed++;
    pulse_run(); tick_1hz = 1; cyc(); tick_1hz = 0;
    checks++; if ({w_state_out, w_tm} !== {2'b01, 16'h0000}) $display("FAIL wrap_max2 got %b %h exp 01 0000", w_state_out, w_tm); else passed++;
    checks++; if (tm !== 16'h0300) $display("FAIL carry_max59 got %h exp 0300", tm); else passed++;
    cyc();
  endtask
  initial begin
    cyc();
    test_reset();
    test_count_up();
    test_adjust();
    test_run_50();
    test_count_down();
    test_laps();
    test_back_to_back();
    test_mid_run_reset();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
